// File: rtl/rotation_parser_if.sv
// Byte stream in from the UART receiver and signed rotation words out to the dial coprocessor.
interface rotation_parser_if #(
    parameter int WIDTH_DOUT = 128
);
    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic [WIDTH_DOUT-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;

    modport master (
        output rx_byte,
        output rx_valid,
        output dout_ready,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  rx_byte,
        input  rx_valid,
        input  dout_ready,
        output dout,
        output dout_valid
    );
endinterface

// File: rtl/rotation_parser.sv
// Parses ASCII rotation lines ("L68", "R48", ...) into signed words held in a one-entry valid/ready register.
//
// state   | meaning
// IDLE    | waiting for 'L' or 'R'; separators ignored
// DIR     | direction seen, no digits yet
// DIGITS  | accumulating decimal digits
// DISCARD | malformed line, skipping to LF or ','
module rotation_parser #(
    parameter int WIDTH_DOUT  = 128,
    parameter int WIDTH_VALUE = 32,
    parameter int MAX_DIGITS  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    rotation_parser_if.slave        bus,
    output logic [15:0]             line_count,
    output logic [2:0]              err_flags,
    input  logic                    clr_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DIR     = 2'd1;
    localparam logic [1:0] DIGITS  = 2'd2;
    localparam logic [1:0] DISCARD = 2'd3;

    localparam int                NDIG_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [NDIG_W-1:0] NDIG_MAX = NDIG_W'(MAX_DIGITS);

    localparam logic [7:0] CH_CR    = 8'h0d;
    localparam logic [7:0] CH_LF    = 8'h0a;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2c;
    localparam logic [7:0] CH_L     = 8'h4c;
    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    logic [1:0]             state, state_n;
    logic [WIDTH_VALUE-1:0] acc, acc_n;
    logic [NDIG_W-1:0]      ndig, ndig_n;
    logic                   neg, neg_n;

    logic is_l, is_r, is_digit, is_term, is_sep, ends_discard;
    logic emit, set_bad, set_ovf, set_ovr, load;
    logic [WIDTH_VALUE-1:0] value;
    logic [WIDTH_DOUT-1:0]  dout_n;

    always_comb begin
        is_l         = (bus.rx_byte == CH_L);
        is_r         = (bus.rx_byte == CH_R);
        is_digit     = (bus.rx_byte >= CH_0) && (bus.rx_byte <= CH_9);
        is_term      = (bus.rx_byte == CH_CR) || (bus.rx_byte == CH_LF) || (bus.rx_byte == CH_COMMA);
        is_sep       = is_term || (bus.rx_byte == CH_SPACE);
        ends_discard = (bus.rx_byte == CH_LF) || (bus.rx_byte == CH_COMMA);
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        ndig_n  = ndig;
        neg_n   = neg;
        emit    = 1'b0;
        set_bad = 1'b0;
        set_ovf = 1'b0;
        if (bus.rx_valid) begin
            case (state)
                IDLE: begin
                    if (is_l || is_r) begin
                        state_n = DIR;
                        neg_n   = is_l;
                        acc_n   = '0;
                        ndig_n  = '0;
                    end else if (!is_sep) begin
                        state_n = DISCARD;
                        set_bad = 1'b1;
                    end
                end
                DIR, DIGITS: begin
                    if (is_digit) begin
                        if (ndig == NDIG_MAX) begin
                            state_n = DISCARD;
                            set_ovf = 1'b1;
                        end else begin
                            // acc*10 as shift-add; low nibble of '0'..'9' is the digit value
                            acc_n   = (acc << 3) + (acc << 1) + WIDTH_VALUE'(bus.rx_byte[3:0]);
                            ndig_n  = ndig + NDIG_W'(1);
                            state_n = DIGITS;
                        end
                    end else if (is_term) begin
                        state_n = IDLE;
                        if (state == DIGITS) begin
                            emit = 1'b1;
                        end else begin
                            set_bad = 1'b1;
                        end
                    end else begin
                        state_n = DISCARD;
                        set_bad = 1'b1;
                    end
                end
                DISCARD: begin
                    if (ends_discard) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        value  = neg ? (WIDTH_VALUE'(0) - acc) : acc;
        dout_n = {{(WIDTH_DOUT - WIDTH_VALUE){value[WIDTH_VALUE-1]}}, value};
        // a transfer in the same cycle frees the register for the new emit
        load    = emit && (!bus.dout_valid || bus.dout_ready);
        set_ovr = emit && bus.dout_valid && !bus.dout_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            acc            <= '0;
            ndig           <= '0;
            neg            <= 1'b0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            line_count     <= '0;
            err_flags      <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            ndig  <= ndig_n;
            neg   <= neg_n;
            if (load) begin
                bus.dout       <= dout_n;
                bus.dout_valid <= 1'b1;
                line_count     <= line_count + 16'd1;
            end else if (bus.dout_valid && bus.dout_ready) begin
                bus.dout_valid <= 1'b0;
            end
            err_flags <= (clr_err ? 3'b000 : err_flags) | {set_ovr, set_ovf, set_bad};
        end
    end

endmodule

// File: doc/rotation_parser.md
ROTATION_PARSER -- requirements
Module: rotation_parser

Interface
REQ-001 SHALL provide parameter WIDTH_DOUT, default 128: width of the output word presented to the dial coprocessor din port.
REQ-002 SHALL provide parameter WIDTH_VALUE, default 32: signed magnitude/result width; bits above it are sign extension.
REQ-003 SHALL provide parameter MAX_DIGITS, default 6: maximum decimal digits accepted per rotation.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all state updates on rising edge.
  rst  in  1  synchronous, active-high reset.
  rx_byte  in  8  ASCII byte from UART receiver.
  rx_valid  in  1  one-cycle strobe: rx_byte is valid; no backpressure to UART.
  dout  out  WIDTH_DOUT  signed rotation, two's complement, sign-extended.
  dout_valid  out  1  dout holds a rotation not yet consumed.
  dout_ready  in  1  downstream accepts dout this cycle.
  line_count  out  16  rotations emitted since reset, wraps at 65535->0.
  err_flags  out  3  sticky: [0] bad char, [1] digit overflow, [2] output overrun.
  clr_err  in  1  clears err_flags.

Function
REQ-005 SHALL use FSM states IDLE, DIR, DIGITS, DISCARD; reset state IDLE.
REQ-006 IDLE: 'L' -> DIR with neg=1, acc=0, ndig=0; 'R' -> DIR with neg=0, acc=0, ndig=0; CR, LF, space, ',' ignored; any other byte -> DISCARD, err_flags[0]=1.
REQ-007 DIR/DIGITS: digit '0'-'9' -> acc = acc*10 + digit, ndig+1, state DIGITS; acc SHALL be WIDTH_VALUE bits unsigned.
REQ-008 Digit arriving when ndig == MAX_DIGITS -> DISCARD, err_flags[1]=1, nothing emitted.
REQ-009 DIGITS: terminator (CR, LF, ',') -> emit rotation, state IDLE.
REQ-010 DIR: terminator (no digits) -> IDLE, err_flags[0]=1, nothing emitted.
REQ-011 DIR/DIGITS: any other byte -> DISCARD, err_flags[0]=1.
REQ-012 DISCARD: ignore all bytes until LF or ',', then IDLE; bytes in DISCARD SHALL NOT set further flags.
REQ-013 Emitted value SHALL be neg ? -acc : acc, sign-extended from WIDTH_VALUE to WIDTH_DOUT; "L0" and "R0" both emit 0.
REQ-014 Latency: terminator accepted at cycle N -> dout/dout_valid updated at N+1.
REQ-015 Output is a one-entry valid/ready register: dout_valid stays high and dout stable until the cycle dout_ready=1.
REQ-016 Transfer occurs when dout_valid && dout_ready; dout_valid drops next cycle unless a new emit occurs in the same cycle, in which case the new value loads and dout_valid stays 1.
REQ-017 Emit while dout_valid && !dout_ready: new rotation dropped, dout unchanged, err_flags[2]=1.
REQ-018 line_count SHALL increment once per emit actually loaded into dout; dropped emits not counted.
REQ-019 rx_valid=0 cycles SHALL not change FSM state or accumulator.
REQ-020 clr_err clears all err_flags; a flag set in the same cycle as clr_err SHALL remain set (set wins).

Reset
REQ-021 rst=1 at any edge SHALL force: FSM IDLE, acc=0, ndig=0, neg=0, dout=0, dout_valid=0, line_count=0, err_flags=0; a partial line is discarded.
REQ-022 rst SHALL override rx_valid, dout_ready and clr_err in the same cycle.
REQ-023 After rst deasserts, the first accepted byte SHALL be processed in state IDLE.

Verification
REQ-024 Bytes "L68\n" with dout_ready=1 -> one cycle after '\n', dout=-68 (all upper bits 1), dout_valid=1 for one cycle, line_count=1.
REQ-025 "R48\r\nL5\n" with dout_ready=0 until after second line -> dout=48 held, second emit dropped, err_flags=3'b100, line_count=1.
REQ-026 "R1234567\n" (MAX_DIGITS=6) -> no emit, err_flags[1]=1; following "R9\n" emits 9.
REQ-027 "X\nL\nR0\n" -> err_flags[0]=1, single emit of 0, line_count=1; clr_err pulse -> err_flags=0.
REQ-028 "L99" then rst pulse then "\nR3\n" -> no emit of -99, single emit of 3, line_count=1.
REQ-029 Back-to-back "R1,R2," with dout_ready high every cycle, including emit coinciding with transfer -> dout sequence 1 then 2, no overrun flag.
